act_writeback: RTL and testbench

- Downstream stage of compute_module. Accepts one signed ALU_WIDTH accumulator result per neuron over a valid/ready handshake.
- Binarizes each result with a sign activation and writes the 1-bit activation into the X memory bank as input for the next layer.
- Tracks the argmax over the layer for final classification.
- Pulses layer_done when the programmed neuron count has been written.

---
 rtl/nn_pkg.sv | 19 +
 rtl/argmax_tracker.sv | 47 ++++
 rtl/act_writeback.sv | 159 +++++++++++++++
 tb/tb_act_writeback.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared widths, FSM encoding and constants for the activation write-back path.
package nn_pkg;

    localparam int unsigned X_ADDR_LEN = 10;
    localparam int unsigned X_DATA_LEN = 1;
    localparam int unsigned X_SEL_LEN  = 2;
    localparam int unsigned ALU_WIDTH  = 12;
    localparam int unsigned CNT_LEN    = 10;

    // Most-negative accumulator value: the starting point for the running max.
    localparam logic [ALU_WIDTH-1:0] ACC_MIN = {1'b1, {(ALU_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } wb_state_e;

endpackage

// File: rtl/argmax_tracker.sv
// Running signed argmax over one layer. Outputs are the post-update view
// (this cycle's clear/compare already applied), so the parent can latch the
// final result on the same edge as the last accept.
module argmax_tracker
    import nn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 en,
    input  logic [CNT_LEN-1:0]   idx,
    input  logic [ALU_WIDTH-1:0] val,
    output logic [CNT_LEN-1:0]   max_idx,
    output logic [ALU_WIDTH-1:0] max_val
);

    logic [CNT_LEN-1:0]   idx_q, idx_d;
    logic [ALU_WIDTH-1:0] val_q, val_d;

    // Strict compare so ties keep the earlier index.
    always_comb begin
        idx_d = idx_q;
        val_d = val_q;
        if (clear) begin
            idx_d = '0;
            val_d = ACC_MIN;
        end else if (en && ($signed(val) > $signed(val_q))) begin
            idx_d = idx;
            val_d = val;
        end
    end

    // Running max registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            val_q <= ACC_MIN;
        end else begin
            idx_q <= idx_d;
            val_q <= val_d;
        end
    end

    assign max_idx = idx_d;
    assign max_val = val_d;

endmodule

// File: rtl/act_writeback.sv
// Sign-activation write-back: takes accumulator results over valid/ready,
// writes one activation bit per neuron into the X bank and pulses layer_done
// with the last write. Define ARGMAX_EN to build the layer argmax tracker;
// without it argmax_idx/argmax_val read 0.
module act_writeback
    import nn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  layer_start,
    input  logic [CNT_LEN-1:0]    layer_len,
    input  logic [X_ADDR_LEN-1:0] x_base,
    input  logic [X_SEL_LEN-1:0]  dst_sel,
    input  logic                  acc_valid,
    input  logic [ALU_WIDTH-1:0]  acc_data,
    output logic                  acc_ready,
    input  logic                  x_busy,
    output logic [X_ADDR_LEN-1:0] x_addr,
    output logic [X_DATA_LEN-1:0] x_data,
    output logic [X_SEL_LEN-1:0]  x_sel,
    output logic                  x_wq,
    output logic                  layer_done,
    output logic [CNT_LEN-1:0]    argmax_idx,
    output logic [ALU_WIDTH-1:0]  argmax_val
);

    wb_state_e             state_q, state_d;
    logic [CNT_LEN-1:0]    len_q, len_d;
    logic [X_ADDR_LEN-1:0] base_q, base_d;
    logic [X_SEL_LEN-1:0]  sel_q, sel_d;
    logic [CNT_LEN-1:0]    cnt_q, cnt_d;
    logic [X_ADDR_LEN-1:0] x_addr_q, x_addr_d;
    logic [X_DATA_LEN-1:0] x_data_q, x_data_d;
    logic [X_SEL_LEN-1:0]  x_sel_q, x_sel_d;
    logic                  x_wq_q, x_wq_d;
    logic                  accept;

    // Next-state, handshake and write-port logic.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        base_d     = base_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        x_addr_d   = x_addr_q;
        x_data_d   = x_data_q;
        x_sel_d    = x_sel_q;
        x_wq_d     = 1'b0;
        acc_ready  = 1'b0;
        accept     = 1'b0;
        layer_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (layer_start) begin
                    len_d   = layer_len;
                    base_d  = x_base;
                    sel_d   = dst_sel;
                    cnt_d   = '0;
                    state_d = (layer_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                acc_ready = ~x_busy;
                accept    = acc_valid & ~x_busy;
                if (accept) begin
                    // Address wraps modulo the X address space.
                    x_addr_d = base_q + X_ADDR_LEN'(cnt_q);
                    x_data_d = X_DATA_LEN'(!acc_data[ALU_WIDTH-1]);
                    x_sel_d  = sel_q;
                    x_wq_d   = 1'b1;
                    cnt_d    = cnt_q + CNT_LEN'(1);
                    if (cnt_d == len_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                layer_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and write-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            len_q    <= '0;
            base_q   <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            x_addr_q <= '0;
            x_data_q <= '0;
            x_sel_q  <= '0;
            x_wq_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            base_q   <= base_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            x_addr_q <= x_addr_d;
            x_data_q <= x_data_d;
            x_sel_q  <= x_sel_d;
            x_wq_q   <= x_wq_d;
        end
    end

    assign x_addr = x_addr_q;
    assign x_data = x_data_q;
    assign x_sel  = x_sel_q;
    assign x_wq   = x_wq_q;

`ifdef ARGMAX_EN
    logic                 am_clear;
    logic                 am_load;
    logic [CNT_LEN-1:0]   am_idx;
    logic [ALU_WIDTH-1:0] am_val;
    logic [CNT_LEN-1:0]   argmax_idx_q;
    logic [ALU_WIDTH-1:0] argmax_val_q;

    assign am_clear = (state_q == StIdle) && layer_start;
    // DONE is only ever entered from IDLE or RUN, so this is the DONE-entry edge.
    assign am_load  = (state_d == StDone);

    argmax_tracker u_argmax_tracker (
        .clk     (clk),
        .rst     (rst),
        .clear   (am_clear),
        .en      (accept),
        .idx     (cnt_q),
        .val     (acc_data),
        .max_idx (am_idx),
        .max_val (am_val)
    );

    // Published result, held until the next layer completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            argmax_idx_q <= '0;
            argmax_val_q <= '0;
        end else if (am_load) begin
            argmax_idx_q <= am_idx;
            argmax_val_q <= am_val;
        end
    end

    assign argmax_idx = argmax_idx_q;
    assign argmax_val = argmax_val_q;
`else
    // Only the sign bit of the result matters without the tracker.
    logic unused_acc_bits;
    assign unused_acc_bits = ^{accept, acc_data[ALU_WIDTH-2:0]};
    assign argmax_idx      = '0;
    assign argmax_val      = '0;
`endif

endmodule

// File: tb/tb_act_writeback.sv
// Directed bench for act_writeback; expectations follow ARGMAX_EN if defined.
module tb_act_writeback;
    import nn_pkg::*;

`ifdef ARGMAX_EN
    localparam bit AmOn = 1'b1;
`else
    localparam bit AmOn = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  layer_start;
    logic [CNT_LEN-1:0]    layer_len;
    logic [X_ADDR_LEN-1:0] x_base;
    logic [X_SEL_LEN-1:0]  dst_sel;
    logic                  acc_valid;
    logic [ALU_WIDTH-1:0]  acc_data;
    logic                  acc_ready;
    logic                  x_busy;
    logic [X_ADDR_LEN-1:0] x_addr;
    logic [X_DATA_LEN-1:0] x_data;
    logic [X_SEL_LEN-1:0]  x_sel;
    logic                  x_wq;
    logic                  layer_done;
    logic [CNT_LEN-1:0]    argmax_idx;
    logic [ALU_WIDTH-1:0]  argmax_val;

    act_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .layer_start (layer_start),
        .layer_len   (layer_len),
        .x_base      (x_base),
        .dst_sel     (dst_sel),
        .acc_valid   (acc_valid),
        .acc_data    (acc_data),
        .acc_ready   (acc_ready),
        .x_busy      (x_busy),
        .x_addr      (x_addr),
        .x_data      (x_data),
        .x_sel       (x_sel),
        .x_wq        (x_wq),
        .layer_done  (layer_done),
        .argmax_idx  (argmax_idx),
        .argmax_val  (argmax_val)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Write / done log captured at the falling edge.
    logic [X_ADDR_LEN-1:0] wr_addr[$];
    logic [X_DATA_LEN-1:0] wr_data[$];
    logic [X_SEL_LEN-1:0]  wr_sel[$];
    int                    wr_cyc[$];
    int                    done_cnt;
    int                    done_cyc;

    logic [ALU_WIDTH-1:0]  vec[0:15];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (x_wq === 1'b1) begin
            wr_addr.push_back(x_addr);
            wr_data.push_back(x_data);
            wr_sel.push_back(x_sel);
            wr_cyc.push_back(cyc);
        end
        if (layer_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log;
        wr_addr.delete();
        wr_data.delete();
        wr_sel.delete();
        wr_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic start_layer(input logic [CNT_LEN-1:0] len, input logic [X_ADDR_LEN-1:0] base,
                               input logic [X_SEL_LEN-1:0] sel);
        layer_start = 1'b1;
        layer_len   = len;
        x_base      = base;
        dst_sel     = sel;
        tick();
        layer_start = 1'b0;
    endtask

    // Presents vec[first..last-1] back to back; optionally pulses a stray layer_start.
    task automatic feed(input int first, input int last, input int ignore_at);
        for (int i = first; i < last; i++) begin
            int g;
            acc_valid = 1'b1;
            acc_data  = vec[i];
            if (i == ignore_at) begin
                layer_start = 1'b1;
                layer_len   = 10'd1;
                x_base      = 10'h200;
            end
            #1;
            g = 0;
            while (acc_ready !== 1'b1 && g < 20) begin
                tick();
                #1;
                g++;
            end
            checks++;
            if (g >= 20) begin
                failures++;
                $display("FAIL handshake_timeout item=%0d acc_ready=%b required=1", i, acc_ready);
            end
            tick();
            layer_start = 1'b0;
        end
        acc_valid = 1'b0;
    endtask

    task automatic test_poweron_reset;
        rst = 1'b1; layer_start = 1'b0; layer_len = '0; x_base = '0; dst_sel = '0;
        acc_valid = 1'b0; acc_data = '0; x_busy = 1'b0;
        repeat (3) tick();
        checks++;
        if ({acc_ready, x_addr, x_data, x_sel, x_wq, layer_done, argmax_idx, argmax_val} !== '0) begin
            failures++;
            $display("FAIL poweron_outputs got=%h required=0",
                     {acc_ready, x_addr, x_data, x_sel, x_wq, layer_done, argmax_idx, argmax_val});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (acc_ready !== 1'b0 || layer_done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset ready=%b done=%b required=0/0", acc_ready, layer_done);
        end
    endtask

    task automatic test_basic;
        logic [X_ADDR_LEN-1:0] ea[4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        logic                  ed[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        clear_log();
        vec[0] = 12'd5; vec[1] = 12'hFFD; vec[2] = 12'd0; vec[3] = 12'h800;
        start_layer(10'd4, 10'h3FE, 2'd2);
        feed(0, 4, -1);
        repeat (3) tick();
        checks++;
        if (wr_addr.size() != 4) begin
            failures++;
            $display("FAIL basic_write_count got=%0d required=4", wr_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i] || wr_sel[i] !== 2'd2
                    || wr_cyc[i] != wr_cyc[0] + i) begin
                    failures++;
                    $display("FAIL basic_write%0d got addr=%h data=%b sel=%0d dcyc=%0d required %h/%b/2/%0d",
                             i, wr_addr[i], wr_data[i], wr_sel[i], wr_cyc[i] - wr_cyc[0], ea[i], ed[i], i);
                end
            end
            checks++;
            if (done_cnt != 1 || done_cyc != wr_cyc[3]) begin
                failures++;
                $display("FAIL basic_done got count=%0d cyc=%0d required 1 at cyc %0d",
                         done_cnt, done_cyc, wr_cyc[3]);
            end
        end
        checks++;
        if (argmax_idx !== (AmOn ? 10'd0 : 10'd0) || argmax_val !== (AmOn ? 12'd5 : 12'd0)) begin
            failures++;
            $display("FAIL basic_argmax got idx=%0d val=%h required idx=0 val=%h",
                     argmax_idx, argmax_val, AmOn ? 12'd5 : 12'd0);
        end
    endtask

    task automatic test_backpressure;
        logic [X_ADDR_LEN-1:0] ea[3] = '{10'h010, 10'h011, 10'h012};
        logic                  ed[3] = '{1'b0, 1'b1, 1'b0};
        clear_log();
        vec[0] = 12'hFFF; vec[1] = 12'd4; vec[2] = 12'hFF9;
        start_layer(10'd3, 10'h010, 2'd1);
        feed(0, 1, -1);
        acc_valid = 1'b1;
        acc_data  = vec[1];
        x_busy    = 1'b1;
        for (int b = 0; b < 2; b++) begin
            #1;
            checks++;
            if (acc_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready_low cycle=%0d got=%b required=0", b, acc_ready);
            end
            tick();
        end
        x_busy = 1'b0;
        feed(1, 3, -1);
        repeat (3) tick();
        checks++;
        if (wr_addr.size() != 3) begin
            failures++;
            $display("FAIL bp_write_count got=%0d required=3", wr_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i] || wr_sel[i] !== 2'd1) begin
                    failures++;
                    $display("FAIL bp_write%0d got addr=%h data=%b sel=%0d required %h/%b/1",
                             i, wr_addr[i], wr_data[i], wr_sel[i], ea[i], ed[i]);
                end
            end
            checks++;
            if (wr_cyc[1] - wr_cyc[0] != 3 || done_cnt != 1 || done_cyc != wr_cyc[2]) begin
                failures++;
                $display("FAIL bp_timing got gap=%0d done=%0d required gap=3 done=1 with last write",
                         wr_cyc[1] - wr_cyc[0], done_cnt);
            end
        end
        checks++;
        if (argmax_idx !== (AmOn ? 10'd1 : 10'd0) || argmax_val !== (AmOn ? 12'd4 : 12'd0)) begin
            failures++;
            $display("FAIL bp_argmax got idx=%0d val=%h", argmax_idx, argmax_val);
        end
    endtask

    task automatic test_argmax;
        logic ed[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        clear_log();
        vec[0] = 12'd7; vec[1] = 12'd12; vec[2] = 12'd12; vec[3] = 12'hFFF;
        start_layer(10'd4, 10'h100, 2'd3);
        feed(0, 4, -1);
        repeat (3) tick();
        checks++;
        if (wr_addr.size() != 4 || done_cnt != 1) begin
            failures++;
            $display("FAIL am_writes got=%0d done=%0d required 4/1", wr_addr.size(), done_cnt);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr[i] !== 10'h100 + 10'(i) || wr_data[i] !== ed[i] || wr_sel[i] !== 2'd3) begin
                    failures++;
                    $display("FAIL am_write%0d got addr=%h data=%b sel=%0d required %h/%b/3",
                             i, wr_addr[i], wr_data[i], wr_sel[i], 10'h100 + 10'(i), ed[i]);
                end
            end
        end
        checks++;
        if (argmax_idx !== (AmOn ? 10'd1 : 10'd0) || argmax_val !== (AmOn ? 12'd12 : 12'd0)) begin
            failures++;
            $display("FAIL am_layer1 got idx=%0d val=%h required idx=%0d val=%h", argmax_idx,
                     argmax_val, AmOn ? 1 : 0, AmOn ? 12'd12 : 12'd0);
        end
        clear_log();
        vec[0] = 12'hFFB; vec[1] = 12'hFF7;
        start_layer(10'd2, 10'h104, 2'd3);
        checks++;
        if (argmax_idx !== (AmOn ? 10'd1 : 10'd0) || argmax_val !== (AmOn ? 12'd12 : 12'd0)) begin
            failures++;
            $display("FAIL am_hold got idx=%0d val=%h", argmax_idx, argmax_val);
        end
        feed(0, 2, -1);
        repeat (3) tick();
        checks++;
        if (argmax_idx !== 10'd0 || argmax_val !== (AmOn ? 12'hFFB : 12'd0)) begin
            failures++;
            $display("FAIL am_layer2 got idx=%0d val=%h required idx=0 val=%h", argmax_idx,
                     argmax_val, AmOn ? 12'hFFB : 12'd0);
        end
        checks++;
        if (wr_addr.size() != 2 || done_cnt != 1) begin
            failures++;
            $display("FAIL am_layer2_writes got=%0d done=%0d required 2/1", wr_addr.size(), done_cnt);
        end
    endtask

    task automatic test_zero_len_and_ignore;
        clear_log();
        layer_start = 1'b1;
        layer_len   = 10'd0;
        x_base      = 10'h055;
        dst_sel     = 2'd1;
        @(posedge clk);
        #1;
        layer_start = 1'b0;
        @(negedge clk);
        checks++;
        if (layer_done !== 1'b1 || x_wq !== 1'b0 || acc_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_done got done=%b wq=%b ready=%b required 1/0/0",
                     layer_done, x_wq, acc_ready);
        end
        checks++;
        if (argmax_idx !== 10'd0 || argmax_val !== (AmOn ? 12'h800 : 12'd0)) begin
            failures++;
            $display("FAIL zero_argmax got idx=%0d val=%h required idx=0 val=%h",
                     argmax_idx, argmax_val, AmOn ? 12'h800 : 12'd0);
        end
        tick();
        checks++;
        if (layer_done !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_pulse got=%b required=0", layer_done);
        end
        repeat (2) tick();
        checks++;
        if (wr_addr.size() != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL zero_writes got writes=%0d done=%0d required 0/1", wr_addr.size(), done_cnt);
        end
        clear_log();
        vec[0] = 12'd1; vec[1] = 12'd1; vec[2] = 12'd1;
        start_layer(10'd3, 10'h020, 2'd0);
        feed(0, 3, 1);
        repeat (3) tick();
        checks++;
        if (wr_addr.size() != 3 || done_cnt != 1) begin
            failures++;
            $display("FAIL ignore_start got writes=%0d done=%0d required 3/1", wr_addr.size(), done_cnt);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr[i] !== 10'h020 + 10'(i) || wr_data[i] !== 1'b1) begin
                    failures++;
                    $display("FAIL ignore_write%0d got addr=%h data=%b required %h/1",
                             i, wr_addr[i], wr_data[i], 10'h020 + 10'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid_layer;
        for (int i = 0; i < 5; i++) vec[i] = 12'd3;
        start_layer(10'd5, 10'h040, 2'd2);
        feed(0, 2, -1);
        acc_valid = 1'b1;
        acc_data  = 12'd3;
        rst       = 1'b1;
        tick();
        clear_log();
        checks++;
        if ({acc_ready, x_addr, x_data, x_sel, x_wq, layer_done, argmax_idx, argmax_val} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h required=0",
                     {acc_ready, x_addr, x_data, x_sel, x_wq, layer_done, argmax_idx, argmax_val});
        end
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        checks++;
        if (wr_addr.size() != 0 || done_cnt != 0 || acc_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_abandon got writes=%0d done=%0d ready=%b required 0/0/0",
                     wr_addr.size(), done_cnt, acc_ready);
        end
        acc_valid = 1'b0;
    endtask

    initial begin
        test_poweron_reset();
        test_basic();
        test_backpressure();
        test_argmax();
        test_zero_len_and_ignore();
        test_reset_mid_layer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
